// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent single-outstanding read and write paths over a word RAM.
// Optional macro AXI_SLAVE_MEM_RANGE_CHECK_EN flags beats beyond MEM_WORDS instead of wrapping.
module axi4_slave_mem #(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned IDWIDTH   = 6,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               awvalid,
  output logic               awready,
  input  logic [IDWIDTH-1:0] awid,
  input  logic [AWIDTH-1:0]  awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic               awlock,
  input  logic [3:0]         awcache,
  input  logic [2:0]         awprot,
  input  logic [3:0]         awqos,
  input  logic [3:0]         awregion,
  input  logic               wvalid,
  output logic               wready,
  input  logic [IDWIDTH-1:0] wid,
  input  logic [DWIDTH-1:0]  wdata,
  input  logic [DWIDTH/8-1:0] wstrb,
  input  logic               wlast,
  output logic               bvalid,
  input  logic               bready,
  output logic [IDWIDTH-1:0] bid,
  output logic [1:0]         bresp,
  input  logic               arvalid,
  output logic               arready,
  input  logic [IDWIDTH-1:0] arid,
  input  logic [AWIDTH-1:0]  araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic               arlock,
  input  logic [3:0]         arcache,
  input  logic [2:0]         arprot,
  input  logic [3:0]         arqos,
  input  logic [3:0]         arregion,
  output logic               rvalid,
  input  logic               rready,
  output logic [IDWIDTH-1:0] rid,
  output logic [DWIDTH-1:0]  rdata,
  output logic [1:0]         rresp,
  output logic               rlast
);

  localparam int unsigned Bytes  = DWIDTH / 8;
  localparam int unsigned BShift = $clog2(Bytes);
  localparam int unsigned MW     = $clog2(MEM_WORDS);
`ifdef AXI_SLAVE_MEM_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [DWIDTH-1:0] mem [MEM_WORDS];

  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] addr,
                                                  input logic [7:0] len, input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [AWIDTH-1:0] incr, mask;
    incr = AWIDTH'(1) << size;
    mask = ((AWIDTH'(len) + AWIDTH'(1)) << size) - AWIDTH'(1);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~mask) | ((addr + incr) & mask);
      default: return addr + incr;
    endcase
  endfunction

  function automatic logic [MW-1:0] word_idx(input logic [AWIDTH-1:0] addr);
    return addr[BShift +: MW];
  endfunction

  function automatic logic out_of_range(input logic [AWIDTH-1:0] addr);
    return RangeCheck && (|addr[AWIDTH-1:BShift+MW]);
  endfunction

  // Write path
  w_state_e w_state_q, w_state_d;
  logic [IDWIDTH-1:0] w_id_q, w_id_d;
  logic [AWIDTH-1:0]  w_addr_q, w_addr_d;
  logic [7:0]         w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]         w_size_q, w_size_d;
  logic [1:0]         w_burst_q, w_burst_d;
  logic               w_err_q, w_err_d;
  logic               aw_hs, w_hs, w_oor;

  assign awready = resetn && (w_state_q == WIdle);
  assign wready  = (w_state_q == WData);
  assign bvalid  = (w_state_q == WResp);
  assign bid     = w_id_q;
  assign bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign w_oor   = out_of_range(w_addr_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      WIdle: if (aw_hs) begin
        w_id_d    = awid;
        w_addr_d  = awaddr;
        w_len_d   = awlen;
        w_size_d  = awsize;
        w_burst_d = awburst;
        w_beat_d  = 8'd0;
        w_err_d   = (awburst == 2'b11);
        w_state_d = WData;
      end
      WData: if (w_hs) begin
        w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        w_beat_d = w_beat_q + 8'd1;
        w_err_d  = w_err_q || w_oor || (wlast && (w_beat_q != w_len_q));
        if (wlast) w_state_d = WResp;
      end
      WResp: if (bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_oor) begin
      for (int b = 0; b < int'(Bytes); b++) begin
        if (wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read path: rdata is registered so it stays stable while stalled and sees pre-write data
  r_state_e r_state_q, r_state_d;
  logic [IDWIDTH-1:0] r_id_q, r_id_d;
  logic [AWIDTH-1:0]  r_addr_q, r_addr_d, rd_addr;
  logic [7:0]         r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]         r_size_q, r_size_d;
  logic [1:0]         r_burst_q, r_burst_d;
  logic               r_berr_q, r_berr_d, r_oor_q;
  logic [DWIDTH-1:0]  rdata_q;
  logic               ar_hs, r_hs, rd_load;

  assign arready = resetn && (r_state_q == RIdle);
  assign rvalid  = (r_state_q == RData);
  assign rid     = r_id_q;
  assign rlast   = rvalid && (r_beat_q == r_len_q);
  assign rdata   = rvalid ? rdata_q : '0;
  assign rresp   = (rvalid && (r_berr_q || r_oor_q)) ? 2'b10 : 2'b00;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign rd_addr = (r_state_q == RIdle) ? araddr
                                        : next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
  assign rd_load = ar_hs || (r_hs && !rlast);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_berr_d  = r_berr_q;
    case (r_state_q)
      RIdle: if (ar_hs) begin
        r_id_d    = arid;
        r_addr_d  = araddr;
        r_len_d   = arlen;
        r_size_d  = arsize;
        r_burst_d = arburst;
        r_beat_d  = 8'd0;
        r_berr_d  = (arburst == 2'b11);
        r_state_d = RData;
      end
      RData: if (r_hs) begin
        if (rlast) begin
          r_state_d = RIdle;
        end else begin
          r_addr_d = rd_addr;
          r_beat_d = r_beat_q + 8'd1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_berr_q  <= 1'b0;
      r_oor_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_berr_q  <= r_berr_d;
      if (rd_load) begin
        r_oor_q <= out_of_range(rd_addr);
        rdata_q <= out_of_range(rd_addr) ? '0 : mem[word_idx(rd_addr)];
      end
    end
  end

  logic unused_ignored;
  assign unused_ignored = ^{awlock, awcache, awprot, awqos, awregion,
                            arlock, arcache, arprot, arqos, arregion, wid};

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: directed writes/reads, monitors compare B and R channels.
module tb_axi4_slave_mem;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 0, wlast = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [5:0] awid = 0, wid = 0, arid = 0, bid, rid;
  logic [31:0] awaddr = 0, araddr = 0;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  logic [127:0] wdata = 0, rdata;
  logic [15:0] wstrb = 0;

  typedef struct packed {
    logic [5:0]   id;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;

  r_exp_t     r_q[$];
  logic [7:0] b_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_slave_mem dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(1'b0), .awcache(4'd0), .awprot(3'd0),
    .awqos(4'd0), .awregion(4'd0),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(1'b0), .arcache(4'd0), .arprot(3'd0),
    .arqos(4'd0), .arregion(4'd0),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // B monitor
  always @(negedge clk) begin
    if (resetn && bvalid && bready) begin
      if (b_q.size() == 0) begin
        check("b_unexpected", 256'(bvalid), 256'(0));
      end else begin
        check("bresp", 256'({bid, bresp}), 256'(b_q[0]));
        void'(b_q.pop_front());
      end
    end
  end

  // R monitor: checks every cycle rvalid is high, so stalled beats must hold
  always @(negedge clk) begin
    if (resetn && rvalid) begin
      if (r_q.size() == 0) begin
        check("r_unexpected", 256'(rvalid), 256'(0));
      end else begin
        check("rbeat", 256'({rid, rdata, rresp, rlast}), 256'(r_q[0]));
        if (rready) void'(r_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input logic [127:0] d0,
                          input logic [15:0] strb, input logic [1:0] exp_resp);
    int t;
    b_q.push_back({id, exp_resp});
    @(posedge clk); #1;
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = 3'd4; awburst = burst;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (awready) break; end
    check("aw_accept", 256'(t < 50), 256'(1));
    @(posedge clk); #1;
    awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1; wdata = d0 + 128'(i); wstrb = strb; wlast = (i == nbeats - 1);
      for (t = 0; t < 50; t++) begin @(negedge clk); if (wready) break; end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    for (t = 0; t < 50 && b_q.size() != 0; t++) @(negedge clk);
    check("b_done", 256'(b_q.size()), 256'(0));
  endtask

  task automatic exp_r(input logic [5:0] id, input logic [127:0] d, input logic [1:0] resp,
                       input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit stall);
    int t;
    @(posedge clk); #1;
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = 3'd4; arburst = burst;
    for (t = 0; t < 50; t++) begin @(negedge clk); if (arready) break; end
    check("ar_accept", 256'(t < 50), 256'(1));
    @(posedge clk); #1;
    arvalid = 0;
    for (int c = 0; c < 100 && r_q.size() != 0; c++) begin
      rready = stall ? (c % 2 == 0) : 1'b1;
      @(posedge clk); #1;
    end
    rready = 0;
    check("r_done", 256'(r_q.size()), 256'(0));
  endtask

  localparam logic [127:0] Beef = 128'hDEADBEEF;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", 256'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid,
                                 rdata, rresp, rlast}), 256'(0));
    @(posedge clk); #1;
    resetn = 1;
    @(negedge clk);
    check("ready_after_reset", 256'({awready, arready}), 256'(2'b11));

    do_write(6'd5, 32'h40, 8'd0, 2'b01, 1, Beef, 16'hFFFF, 2'b00);
    exp_r(6'd9, Beef, 2'b00, 1'b1);
    do_read(6'd9, 32'h40, 8'd0, 2'b01, 1'b0);

    // INCR burst, read back with stalls
    do_write(6'd3, 32'h100, 8'd3, 2'b01, 4, 128'd1, 16'hFFFF, 2'b00);
    exp_r(6'd4, 128'd1, 2'b00, 1'b0);
    exp_r(6'd4, 128'd2, 2'b00, 1'b0);
    exp_r(6'd4, 128'd3, 2'b00, 1'b0);
    exp_r(6'd4, 128'd4, 2'b00, 1'b1);
    do_read(6'd4, 32'h100, 8'd3, 2'b01, 1'b1);

    // WRAP burst from 0x130 lands at 0x130, 0x100, 0x110, 0x120
    do_write(6'd7, 32'h130, 8'd3, 2'b10, 4, 128'hA0, 16'hFFFF, 2'b00);
    exp_r(6'd1, 128'hA0, 2'b00, 1'b1); do_read(6'd1, 32'h130, 8'd0, 2'b01, 1'b0);
    exp_r(6'd1, 128'hA1, 2'b00, 1'b1); do_read(6'd1, 32'h100, 8'd0, 2'b01, 1'b0);
    exp_r(6'd1, 128'hA2, 2'b00, 1'b1); do_read(6'd1, 32'h110, 8'd0, 2'b01, 1'b0);
    exp_r(6'd1, 128'hA3, 2'b00, 1'b1); do_read(6'd1, 32'h120, 8'd0, 2'b01, 1'b0);

    // Partial strobe clears the low 4 bytes only
    do_write(6'd6, 32'h200, 8'd0, 2'b01, 1, {128{1'b1}}, 16'hFFFF, 2'b00);
    do_write(6'd6, 32'h200, 8'd0, 2'b01, 1, 128'd0, 16'h000F, 2'b00);
    exp_r(6'd6, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000, 2'b00, 1'b1);
    do_read(6'd6, 32'h200, 8'd0, 2'b01, 1'b0);

    // Early wlast and reserved burst type give SLVERR
    do_write(6'd2, 32'h300, 8'd3, 2'b01, 2, 128'h55, 16'hFFFF, 2'b10);
    do_write(6'd1, 32'h340, 8'd0, 2'b11, 1, 128'h66, 16'hFFFF, 2'b10);
    exp_r(6'd8, 128'hA1, 2'b10, 1'b0);
    exp_r(6'd8, 128'hA2, 2'b10, 1'b1);
    do_read(6'd8, 32'h100, 8'd1, 2'b11, 1'b0);

    // FIXED burst re-reads the same word
    exp_r(6'd10, Beef, 2'b00, 1'b0);
    exp_r(6'd10, Beef, 2'b00, 1'b1);
    do_read(6'd10, 32'h40, 8'd1, 2'b00, 1'b0);

`ifdef AXI_SLAVE_MEM_RANGE_CHECK_EN
    exp_r(6'd11, 128'd0, 2'b10, 1'b1);
    do_read(6'd11, 32'h4040, 8'd0, 2'b01, 1'b0);
    do_write(6'd12, 32'h4040, 8'd0, 2'b01, 1, 128'h77, 16'hFFFF, 2'b10);
    exp_r(6'd13, Beef, 2'b00, 1'b1);
    do_read(6'd13, 32'h40, 8'd0, 2'b01, 1'b0);
`else
    // Word index wraps modulo MEM_WORDS: 0x4040 aliases 0x40
    exp_r(6'd11, Beef, 2'b00, 1'b1);
    do_read(6'd11, 32'h4040, 8'd0, 2'b01, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("queues_empty", 256'(b_q.size() + r_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
Synthesizable AXI4 slave memory responder that attaches to a master port (for example the CoralNPU core master port). It accepts AW/W/AR requests and returns B/R responses. Read and write paths are independent; each path has one transaction outstanding at a time. The backing store is a word-addressed RAM of DWIDTH-bit words.

Parameters:
AWIDTH, 32, address width
DWIDTH, 128, data width in bits (power of two, >= 32)
IDWIDTH, 6, transaction ID width
MEM_WORDS, 1024, RAM depth in DWIDTH-bit words (power of two)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
awvalid/awready  input/output  1/1  AW handshake
awid awaddr awlen awsize awburst  input  IDWIDTH/AWIDTH/8/3/2  AW payload
awlock awcache awprot awqos awregion  input  1/4/3/4/4  accepted, ignored
wvalid/wready  input/output  1/1  W handshake
wid wdata wstrb wlast  input  IDWIDTH/DWIDTH/DWIDTH/8/1  W payload (wid ignored)
bvalid/bready  output/input  1/1  B handshake
bid bresp  output  IDWIDTH/2  write response
arvalid/arready  input/output  1/1  AR handshake
arid araddr arlen arsize arburst  input  IDWIDTH/AWIDTH/8/3/2  AR payload
arlock arcache arprot arqos arregion  input  1/4/3/4/4  ignored
rvalid/rready  output/input  1/1  R handshake
rid rdata rresp rlast  output  IDWIDTH/DWIDTH/2/1  read data

Behaviour:
- Reset: all outputs 0; FSMs go to IDLE; RAM contents are not reset. Reset asserted mid-burst aborts the burst immediately; beats already written remain in RAM.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch id, addr, len, size and burst; clear the beat count; go to W_DATA.
  - W_DATA: wready=1. Each handshake writes the byte lanes enabled by wstrb at word index addr>>log2(DWIDTH/8), then advances the address.
  - On a beat with wlast=1, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. Hold until bready, then go to W_IDLE.
  - Minimum write latency: AW accepted at cycle 0, first W beat cycle 1, bvalid the cycle after the last beat.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch the request and go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rdata=RAM[current word], rlast=(beat==arlen).
  - rdata and rlast are held stable while rready=0. On the handshake, advance; after the last beat, go to R_IDLE.
  - The first rvalid appears 1 cycle after AR acceptance.
- Address advance:
  - FIXED (00): address unchanged.
  - INCR (01): addr += 2^size.
  - WRAP (10): increment within an aligned window of (len+1)*2^size bytes.
  - Unsupported burst 11: treated as INCR; response is SLVERR.
- Narrow transfers (2^size < DWIDTH/8) use the full word; lane selection is by wstrb only.
- bresp:
  - OKAY (00) normally.
  - SLVERR (10) if the burst type was 11, if any beat was out of range (see Optional Feature), or if wlast arrived on a beat count != awlen.
- rresp: per beat, OKAY or SLVERR by the same rules.
- Simultaneous AW and AR acceptance is allowed. A read and a write to the same word in the same cycle return the old data.

Optional Feature:
AXI_SLAVE_MEM_RANGE_CHECK_EN.
- Defined: a beat whose word index >= MEM_WORDS is out of range.
  - Write beats: dropped; the response is SLVERR.
  - Read beats: return rdata=0, rresp=SLVERR.
- Undefined: the word index is taken modulo MEM_WORDS and every in-spec beat is OKAY.

Test Plan:
- Reset then idle -> all outputs 0 during reset; awready=arready=1 on the first cycle after resetn rises.
- Single write awaddr=0x40, awlen=0, wdata=0x...DEADBEEF, wstrb all ones, then read araddr=0x40 -> bresp=00, bid=awid; rdata=0x...DEADBEEF, rlast=1, rresp=00.
- INCR burst awlen=3, size=4, addr=0x100, data 1..4; read back with rready toggling 1,0,1 -> rdata 1,2,3,4 in order, held stable while stalled; rlast only on beat 4.
- WRAP burst len=3, size=4, start 0x130 -> beats land at 0x130, 0x100, 0x110, 0x120.
- Partial strobe wstrb=0x000F over a word of all ones, write 0 -> read returns the word with its low 4 bytes cleared.
- With AXI_SLAVE_MEM_RANGE_CHECK_EN defined, read at MEM_WORDS*16 -> rresp=10, rdata=0; write with wlast on beat 2 of awlen=3 -> bresp=10.
